// File: rtl/sdram_copy_if.sv
// Avalon-MM master bus between the copy sequencer and the SDRAM controller slave.
interface sdram_copy_if #(
  parameter int AW = 32
) ();
  logic [AW-1:0] address;
  logic          read;
  logic          write;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          readdatavalid;
  logic          waitrequest;

  modport master (
    output address, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/sdram_copy_sequencer.sv
// Copies len 32-bit words from src_addr to dst_addr over Avalon-MM, staging
// each chunk of up to DEPTH words in a local buffer.
//
// state  | meaning
// IDLE   | waiting for a start edge
// READ   | issuing pipelined reads for the current chunk
// RDWAIT | all reads issued, collecting outstanding read data
// WRITE  | writing the buffered chunk to the destination
// DONE   | copy finished, done high, a new start edge restarts
module sdram_copy_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 32,
  parameter int LW    = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [LW-1:0] len,
  output logic          done,
  output logic [3:0]    state_code,
  sdram_copy_if.master  avm
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_RDWAIT = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic          start_q, start_edge;
  logic [AW-1:0] src, dst;
  logic [LW-1:0] rem;
  logic [CW-1:0] chunk, issued, rcv, wptr;
  logic [31:0]   data_buf [DEPTH];
  logic          rd_acc, wr_acc, last_rd, last_wr, cap, rcv_full;

  function automatic logic [CW-1:0] chunk_of(input logic [LW-1:0] n);
    if (32'(n) >= DEPTH) return CW'(DEPTH);
    else return CW'(n);
  endfunction

  assign start_edge = start & ~start_q;
  assign rd_acc     = (state == S_READ)  && !avm.waitrequest;
  assign wr_acc     = (state == S_WRITE) && !avm.waitrequest;
  assign last_rd    = rd_acc && ((issued + CW'(1)) == chunk);
  assign last_wr    = wr_acc && ((wptr + CW'(1)) == chunk);
  // Late read data after a reset or abort lands in IDLE/DONE and is dropped here.
  assign cap        = avm.readdatavalid && ((state == S_READ) || (state == S_RDWAIT));
  assign rcv_full   = (rcv == chunk) || (cap && ((rcv + CW'(1)) == chunk));

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    done          = 1'b0;
    avm.read      = 1'b0;
    avm.write     = 1'b0;
    avm.address   = '0;
    avm.writedata = '0;
    state_code    = {1'b0, state};
    case (state)
      S_IDLE: begin
        if (start_edge) state_nxt = (len == '0) ? S_DONE : S_READ;
      end
      S_READ: begin
        avm.read    = 1'b1;
        avm.address = src;
        if (last_rd) state_nxt = S_RDWAIT;
      end
      S_RDWAIT: begin
        if (rcv_full) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        avm.write     = 1'b1;
        avm.address   = dst;
        avm.writedata = data_buf[wptr[IW-1:0]];
        if (last_wr) state_nxt = (rem != LW'(1)) ? S_READ : S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start_edge) state_nxt = (len == '0) ? S_DONE : S_READ;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      start_q <= 1'b0;
      src     <= '0;
      dst     <= '0;
      rem     <= '0;
      chunk   <= '0;
      issued  <= '0;
      rcv     <= '0;
      wptr    <= '0;
    end else begin
      start_q <= start;
      case (state)
        S_IDLE, S_DONE: begin
          if (start_edge) begin
            src    <= src_addr;
            dst    <= dst_addr;
            rem    <= len;
            chunk  <= chunk_of(len);
            issued <= '0;
            rcv    <= '0;
          end
        end
        S_READ: begin
          if (rd_acc) begin
            src    <= src + AW'(4);
            issued <= issued + CW'(1);
          end
        end
        S_RDWAIT: begin
          if (rcv_full) wptr <= '0;
        end
        S_WRITE: begin
          if (wr_acc) begin
            dst  <= dst + AW'(4);
            wptr <= wptr + CW'(1);
            rem  <= rem - LW'(1);
          end
          // Next chunk is sized from what remains after this last accept.
          if (last_wr) begin
            chunk  <= chunk_of(rem - LW'(1));
            issued <= '0;
            rcv    <= '0;
          end
        end
        default: ;
      endcase
      if (cap) rcv <= rcv + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && cap) data_buf[rcv[IW-1:0]] <= avm.readdata;
  end

endmodule

// File: tb/tb_sdram_copy_sequencer.sv
// Scoreboard bench: expected bus transactions are queued at start, a negedge
// slave/monitor process models the SDRAM and pops/compares on every accept.
module tb_sdram_copy_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0, dst_addr = '0;
  logic [15:0] len = '0;
  logic        done;
  logic [3:0]  state_code;

  sdram_copy_if #(.AW(32)) bus ();

  sdram_copy_sequencer #(.DEPTH(16), .AW(32), .LW(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .done       (done),
    .state_code (state_code),
    .avm        (bus)
  );

  always #10 clk = ~clk;

  typedef struct { int due; logic [31:0] data; } pend_t;
  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;

  int          checks = 0, failures = 0;
  int          stall_pct = 0, rd_lat = 2, cyc = 0;
  int          n_rd = 0, n_wr = 0, n_valid = 0, cur_len = 0;
  pend_t       rq[$];
  logic [31:0] exp_rd[$];
  wr_t         exp_wr[$];
  bit          log_sc = 0;
  logic [3:0]  sc_log[$];
  bit          prev_stall_rd = 0, prev_stall_wr = 0;
  logic [31:0] prev_addr = '0, prev_data = '0;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // SDRAM slave model plus monitor; all decisions for the next posedge made here.
  always @(negedge clk) begin
    int need;
    cyc++;
    if (prev_stall_rd) begin
      check("rd_hold_req", 32'(bus.read), 1);
      check("rd_hold_addr", bus.address, prev_addr);
    end
    if (prev_stall_wr) begin
      check("wr_hold_req", 32'(bus.write), 1);
      check("wr_hold_addr", bus.address, prev_addr);
      check("wr_hold_data", bus.writedata, prev_data);
    end
    bus.waitrequest   = (stall_pct > 0) && ($urandom_range(99) < stall_pct);
    bus.readdatavalid = 1'b0;
    bus.readdata      = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      bus.readdatavalid = 1'b1;
      bus.readdata      = rq[0].data;
      void'(rq.pop_front());
      n_valid++;
    end
    if (bus.read && !bus.waitrequest) begin
      n_rd++;
      if (exp_rd.size() == 0) check("unexpected_read", bus.address, 32'hxxxx_xxxx);
      else check("rd_addr", bus.address, exp_rd.pop_front());
      rq.push_back('{cyc + rd_lat, pat(bus.address)});
    end
    if (bus.write && !bus.waitrequest) begin
      need = ((n_wr / 16) + 1) * 16;
      if (need > cur_len) need = cur_len;
      check("chunk_read_before_write", 32'(n_valid >= need), 1);
      n_wr++;
      if (exp_wr.size() == 0) check("unexpected_write", bus.address, 32'hxxxx_xxxx);
      else begin
        wr_t w;
        w = exp_wr.pop_front();
        check("wr_addr", bus.address, w.a);
        check("wr_data", bus.writedata, w.d);
      end
    end
    prev_stall_rd = bus.read && bus.waitrequest;
    prev_stall_wr = bus.write && bus.waitrequest;
    prev_addr     = bus.address;
    prev_data     = bus.writedata;
    if (log_sc && (sc_log.size() == 0 || sc_log[$] != state_code)) sc_log.push_back(state_code);
  end

  task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input int l);
    for (int i = 0; i < l; i++) begin
      exp_rd.push_back(s + 32'(4 * i));
      exp_wr.push_back('{d + 32'(4 * i), pat(s + 32'(4 * i))});
    end
    n_rd = 0; n_wr = 0; n_valid = 0; cur_len = l;
    src_addr = s; dst_addr = d; len = 16'(l);
    start = 1'b1;
    tick();
    if (l != 0) check("first_read_latency", 32'(bus.read), 1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int k = 0;
    while (!done && k < max) begin
      tick();
      k++;
    end
    check("done_reached", 32'(done), 1);
    check("reads_left", exp_rd.size(), 0);
    check("writes_left", exp_wr.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_state"}, 32'(state_code), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_read"}, 32'(bus.read), 0);
    check({tag, "_write"}, 32'(bus.write), 0);
    check({tag, "_addr"}, bus.address, 0);
    check({tag, "_wdata"}, bus.writedata, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int k;
    reset_n = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    reset_n = 1'b1;
    tick();

    // Single short chunk with state code trace.
    sc_log.delete();
    sc_log.push_back(state_code);
    log_sc = 1;
    start_copy(32'h100, 32'h800, 4);
    wait_done(200);
    log_sc = 0;
    check("state_trace_len", sc_log.size(), 5);
    for (int i = 0; i < 5 && i < sc_log.size(); i++) check("state_trace", 32'(sc_log[i]), i);
    check("t1_writes", n_wr, 4);

    // Three chunks: 16, 16, 8.
    start_copy(32'h1000, 32'h4000, 40);
    wait_done(2000);
    check("t2_reads", n_rd, 40);
    check("t2_writes", n_wr, 40);

    // Random stalls.
    stall_pct = 50;
    start_copy(32'h2000, 32'h6000, 20);
    wait_done(3000);
    stall_pct = 0;
    check("t3_writes", n_wr, 20);

    // Address wrap past the top.
    start_copy(32'hFFFF_FFF8, 32'hFFFF_FFFC, 4);
    wait_done(200);

    // Zero length: no traffic, done after two cycles.
    start_copy(32'h300, 32'h900, 0);
    tick();
    check("len0_done", 32'(done), 1);
    repeat (3) tick();
    check("len0_reads", n_rd, 0);
    check("len0_writes", n_wr, 0);

    // Restart from DONE, then ignore start edges during WRITE.
    start_copy(32'h500, 32'hA00, 8);
    check("restart_done_low", 32'(done), 0);
    k = 0;
    while (!bus.write && k < 200) begin tick(); k++; end
    check("t5_reached_write", 32'(bus.write), 1);
    src_addr = 32'hDEAD_0000; dst_addr = 32'hBEEF_0000; len = 16'd3;
    start = 1'b1; tick(); start = 1'b0; tick(); start = 1'b1; tick(); start = 1'b0;
    wait_done(300);
    check("t5_writes", n_wr, 8);
    start_copy(32'h700, 32'hB00, 2);
    check("second_start_done_low", 32'(done), 0);
    wait_done(200);

    // Reset with reads outstanding; late read data must be ignored.
    rd_lat = 4;
    start_copy(32'h800, 32'hC00, 8);
    k = 0;
    while (n_rd < 2 && k < 100) begin tick(); k++; end
    check("t6_two_reads", n_rd, 2);
    reset_n = 1'b0;
    tick();
    exp_rd.delete(); exp_wr.delete(); cur_len = 0;
    check_idle_outputs("midreset");
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("late_valid_state", 32'(state_code), 0);
      check("late_valid_read", 32'(bus.read), 0);
    end
    check("late_valids_seen", 32'(n_valid >= 2), 1);
    rd_lat = 2;
    start_copy(32'h100, 32'h200, 3);
    wait_done(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
